adc_conv_sequencer: RTL and testbench

Scan controller for the 10-bit SAR ADC conversion FSM. It generates `st_conv` sampling/conversion pulses and drives the analog input mux select. It runs a comparator-offset calibration conversion on request, averages 2^k conversions per channel, and delivers one result per enabled channel over a valid/ready stream. It sits between the system control logic and the ADC FSM, and is the only driver of the ADC's `st_conv` and `cal` inputs.

---
 rtl/adc_seq_pkg.sv | 32 +++
 rtl/adc_done_sync.sv | 24 ++
 rtl/adc_conv_sequencer.sv | 188 ++++++++++++++++++
 tb/tb_adc_conv_sequencer.sv | 388 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_seq_pkg.sv
// adc_seq_pkg: shared types, widths and helpers for the ADC conversion sequencer.
//   state_t  - sequencer FSM state encoding
//   next_set - lowest set mask bit at or above a starting index
package adc_seq_pkg;

    localparam int ADC_W = 10;  // ADC result width
    localparam int ACC_W = 13;  // holds 8 x 1023
    localparam int CH_W  = 2;   // channel index width
    localparam int TO_W  = 8;   // done-timeout counter width

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_SAMPLE,
        S_CONV,
        S_ACC,
        S_OUT,
        S_NEXT
    } state_t;

    // Returns {found, index} of the lowest set bit of mask whose index is >= from.
    // 'from' is one bit wider than a channel index so "past the last channel" is representable.
    function automatic logic [CH_W:0] next_set(input logic [3:0] mask, input logic [CH_W:0] from);
        logic [CH_W:0] r;
        r = '0;
        for (int i = 3; i >= 0; i--) begin
            if (mask[i] && (3'(i) >= from)) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/adc_done_sync.sv
// adc_done_sync: brings the asynchronous ADC done flag into the clkin domain and
// turns its rising edge into a single-cycle pulse.
//   clkin - block clock
//   rst   - asynchronous active-high reset
//   d     - raw adc_done
//   pulse - one-cycle pulse on the synchronized rising edge
module adc_done_sync (
    input  logic clkin,
    input  logic rst,
    input  logic d,
    output logic pulse
);

    // sr[1:0] is the two-flop synchronizer, sr[2] is the previous synchronized level
    logic [2:0] sr;

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) sr <= '0;
        else     sr <= {sr[1:0], d};
    end

    assign pulse = sr[1] & ~sr[2];

endmodule

// File: rtl/adc_conv_sequencer.sv
// adc_conv_sequencer: scan controller for the SAR ADC conversion FSM.
// Runs an offset calibration on request, then scans enabled channels in ascending
// order, averaging 2^k conversions each, and streams one result per channel.
//   clkin, rst            - clock, asynchronous active-high reset
//   start, ch_mask,       - scan request with channel mask and averaging exponent
//   avg_log2
//   cal_req               - calibration request (latched in any state)
//   adc_done, adc_result  - ADC handshake (done is asynchronous)
//   st_conv, cal, ch_sel  - ADC control and analog mux select
//   out_data, out_ch,     - averaged result stream (valid/ready)
//   out_valid, out_ready
//   busy, timeout_err     - status; timeout_err is sticky
module adc_conv_sequencer
    import adc_seq_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int SAMPLE_CYC = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic             clkin,
    input  logic             rst,
    input  logic             start,
    input  logic             cal_req,
    input  logic [NCH-1:0]   ch_mask,
    input  logic [1:0]       avg_log2,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_result,
    output logic             st_conv,
    output logic             cal,
    output logic [CH_W-1:0]  ch_sel,
    output logic [ADC_W-1:0] out_data,
    output logic [CH_W-1:0]  out_ch,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             timeout_err
);

    state_t           state;
    logic [3:0]       mask_r;
    logic [1:0]       k_r;
    logic             start_pend;
    logic             cal_pend;
    logic [2:0]       conv_cnt;
    logic [ACC_W-1:0] acc;
    logic [TO_W-1:0]  to_cnt;
    logic [7:0]       smp_cnt;
    logic             done_pulse;

    adc_done_sync u_sync (
        .clkin (clkin),
        .rst   (rst),
        .d     (adc_done),
        .pulse (done_pulse)
    );

    logic [ACC_W-1:0] acc_sum;
    logic [CH_W:0]    first_in, first_pd, nxt;
    logic             avg_last;

    assign acc_sum  = acc + ACC_W'(adc_result);
    assign first_in = next_set(4'(ch_mask), 3'd0);   // found bit doubles as "mask non-zero"
    assign first_pd = next_set(mask_r, 3'd0);
    assign nxt      = next_set(mask_r, {1'b0, ch_sel} + 3'd1);
    // conv_cnt reaches 2^k - 1 on the last conversion of a channel
    assign avg_last = (conv_cnt == {k_r == 2'd3, k_r[1], |k_r});
    assign busy     = (state != S_IDLE);

    always_ff @(posedge clkin or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            mask_r      <= '0;
            k_r         <= '0;
            start_pend  <= 1'b0;
            cal_pend    <= 1'b0;
            conv_cnt    <= '0;
            acc         <= '0;
            to_cnt      <= '0;
            smp_cnt     <= '0;
            st_conv     <= 1'b0;
            cal         <= 1'b0;
            ch_sel      <= '0;
            out_data    <= '0;
            out_ch      <= '0;
            out_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (cal_req) cal_pend <= 1'b1;
            case (state)
                S_IDLE: begin
                    acc      <= '0;
                    conv_cnt <= '0;
                    if (cal_pend || cal_req) begin
                        // calibration wins; a simultaneous start waits in start_pend
                        state  <= S_ARM;
                        cal    <= 1'b1;
                        ch_sel <= '0;
                        if (start && first_in[CH_W]) begin
                            start_pend  <= 1'b1;
                            mask_r      <= 4'(ch_mask);
                            k_r         <= avg_log2;
                            timeout_err <= 1'b0;
                        end
                    end else if (start_pend && first_pd[CH_W]) begin
                        state      <= S_ARM;
                        start_pend <= 1'b0;
                        ch_sel     <= first_pd[CH_W-1:0];
                    end else if (start && first_in[CH_W]) begin
                        state       <= S_ARM;
                        mask_r      <= 4'(ch_mask);
                        k_r         <= avg_log2;
                        timeout_err <= 1'b0;
                        ch_sel      <= first_in[CH_W-1:0];
                    end else begin
                        start_pend <= 1'b0;
                    end
                end
                S_ARM: begin
                    state   <= S_SAMPLE;
                    st_conv <= 1'b1;
                    smp_cnt <= 8'(SAMPLE_CYC - 1);
                end
                S_SAMPLE: begin
                    if (smp_cnt == '0) begin
                        state   <= S_CONV;
                        st_conv <= 1'b0;
                        to_cnt  <= TO_W'(TIMEOUT);
                    end else begin
                        smp_cnt <= smp_cnt - 8'd1;
                    end
                end
                S_CONV: begin
                    if (done_pulse) begin
                        state <= S_ACC;
                    end else if (to_cnt <= TO_W'(1)) begin
                        // ADC never answered: abandon the whole operation
                        state       <= S_IDLE;
                        timeout_err <= 1'b1;
                        st_conv     <= 1'b0;
                        cal         <= 1'b0;
                        cal_pend    <= cal_req;
                        start_pend  <= 1'b0;
                        acc         <= '0;
                    end else begin
                        to_cnt <= to_cnt - TO_W'(1);
                    end
                end
                S_ACC: begin
                    acc      <= acc_sum;
                    conv_cnt <= conv_cnt + 3'd1;
                    if (cal) begin
                        // calibration result is consumed by the ADC itself
                        state       <= S_IDLE;
                        cal         <= 1'b0;
                        cal_pend    <= cal_req;
                        timeout_err <= 1'b0;
                        acc         <= '0;
                    end else if (avg_last) begin
                        state     <= S_OUT;
                        out_valid <= 1'b1;
                        out_data  <= ADC_W'(acc_sum >> k_r);
                        out_ch    <= ch_sel;
                    end else begin
                        state <= S_ARM;
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        state     <= S_NEXT;
                        out_valid <= 1'b0;
                        acc       <= '0;
                        conv_cnt  <= '0;
                    end
                end
                S_NEXT: begin
                    if (nxt[CH_W]) begin
                        state  <= S_ARM;
                        ch_sel <= nxt[CH_W-1:0];
                    end else begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adc_conv_sequencer.sv
// tb_adc_conv_sequencer: self-checking bench for adc_conv_sequencer with a
// behavioural ADC model and a result scoreboard.
module tb_adc_conv_sequencer;

    localparam int SAMPLE_CYC = 4;
    localparam int TIMEOUT    = 255;

    logic       clkin = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic       cal_req = 1'b0;
    logic [3:0] ch_mask = '0;
    logic [1:0] avg_log2 = '0;
    logic       adc_done = 1'b0;
    logic [9:0] adc_result = '0;
    logic       out_ready = 1'b1;
    logic       st_conv, cal, out_valid, busy, timeout_err;
    logic [1:0] ch_sel, out_ch;
    logic [9:0] out_data;

    always #5 clkin = ~clkin;

    adc_conv_sequencer #(.NCH(4), .SAMPLE_CYC(SAMPLE_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clkin(clkin), .rst(rst), .start(start), .cal_req(cal_req), .ch_mask(ch_mask),
        .avg_log2(avg_log2), .adc_done(adc_done), .adc_result(adc_result),
        .st_conv(st_conv), .cal(cal), .ch_sel(ch_sel), .out_data(out_data),
        .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
        .busy(busy), .timeout_err(timeout_err)
    );

    int n_chk = 0;
    int n_pass = 0;

    // ADC model: after st_conv falls, wait adc_dly cycles, then raise done with the next value
    logic       adc_dead = 1'b0;
    int         adc_dly = 20;
    int         adc_idx = 0;
    logic [9:0] adc_vals[$];

    initial begin : adc_model
        logic [9:0] v;
        wait (rst === 1'b0);
        forever begin
            @(negedge st_conv);
            if (!rst && !adc_dead) begin
                v = (adc_idx < adc_vals.size()) ? adc_vals[adc_idx] : 10'd0;
                adc_idx++;
                repeat (adc_dly) @(posedge clkin);
                #1;
                adc_result = v;
                adc_done = 1'b1;
            end
            @(posedge st_conv or posedge rst);
            adc_done = 1'b0;
        end
    end

    // monitor: st_conv pulses, pulse widths, out_valid cycles, completed transfers
    int          pulse_cnt = 0;
    int          bad_w = 0;
    int          ov_cycles = 0;
    int          mon_w = 0;
    logic        mon_prev = 1'b0;
    logic [2:0]  rise_q[$];   // {cal, ch_sel} at each st_conv rise
    logic [11:0] got_q[$];    // {out_ch, out_data} per transfer

    always @(negedge clkin) begin
        if (st_conv && !mon_prev) begin
            pulse_cnt++;
            rise_q.push_back({cal, ch_sel});
            mon_w = 1;
        end else if (st_conv) begin
            mon_w++;
        end else if (mon_prev && !rst && mon_w != SAMPLE_CYC) begin
            bad_w++;
        end
        if (out_valid) ov_cycles++;
        if (out_valid && out_ready) got_q.push_back({out_ch, out_data});
        mon_prev = st_conv;
    end

    logic [11:0] exp_q[$];
    int          gi = 0;

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clkin);
            #1;
        end
    endtask

    task automatic wait_idle(input int budget, output bit ok);
        int quiet = 0;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            tick();
            if (!busy) quiet++;
            else quiet = 0;
            if (quiet >= 4) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic pulse_start(input logic [3:0] m, input logic [1:0] k, input logic with_cal);
        ch_mask = m;
        avg_log2 = k;
        start = 1'b1;
        cal_req = with_cal;
        tick();
        start = 1'b0;
        cal_req = 1'b0;
    endtask

    task automatic test_reset();
        n_chk++;
        if ({st_conv, cal, out_valid, busy, timeout_err, ch_sel, out_ch, out_data} !== '0)
            $display("FAIL reset_values: got %b required 0",
                     {st_conv, cal, out_valid, busy, timeout_err, ch_sel, out_ch, out_data});
        else n_pass++;
        rst = 1'b0;
        tick(2);
        n_chk++;
        if (busy !== 1'b0) $display("FAIL reset_idle: busy %b required 0", busy);
        else n_pass++;
    endtask

    task automatic test_cal();
        int p0 = pulse_cnt;
        int b0 = bad_w;
        int o0 = ov_cycles;
        int r0 = rise_q.size();
        bit ok;
        adc_vals.push_back(10'd0);
        cal_req = 1'b1;
        tick();
        cal_req = 1'b0;
        tick();
        n_chk++;
        if (busy !== 1'b1) $display("FAIL cal_busy: busy %b required 1", busy);
        else n_pass++;
        wait_idle(400, ok);
        n_chk++;
        if (!ok) $display("FAIL cal_done: busy %b required 0 within budget", busy);
        else n_pass++;
        n_chk++;
        if (pulse_cnt - p0 != 1 || rise_q.size() != r0 + 1 || rise_q[r0] !== 3'b100)
            $display("FAIL cal_pulse: %0d pulses, last {cal,ch_sel}=%b required 1 pulse with 100",
                     pulse_cnt - p0, rise_q[rise_q.size()-1]);
        else n_pass++;
        n_chk++;
        if (ov_cycles != o0 || bad_w != b0 || cal !== 1'b0)
            $display("FAIL cal_quiet: out_valid cycles %0d bad widths %0d cal %b required 0 0 0",
                     ov_cycles - o0, bad_w - b0, cal);
        else n_pass++;
    endtask

    task automatic test_scan();
        int p0 = pulse_cnt;
        int b0 = bad_w;
        int r0 = rise_q.size();
        int seq_bad = 0;
        bit ok;
        logic [11:0] e;
        adc_vals.push_back(10'd100); adc_vals.push_back(10'd101);
        adc_vals.push_back(10'd102); adc_vals.push_back(10'd104);
        repeat (4) adc_vals.push_back(10'd1023);
        exp_q.push_back({2'd1, 10'd101});
        exp_q.push_back({2'd3, 10'd1023});
        out_ready = 1'b1;
        pulse_start(4'b1010, 2'd2, 1'b0);
        wait_idle(1500, ok);
        n_chk++;
        if (!ok) $display("FAIL scan_done: busy %b required 0 within budget", busy);
        else n_pass++;
        n_chk++;
        if (pulse_cnt - p0 != 8 || bad_w != b0)
            $display("FAIL scan_pulses: %0d pulses %0d bad widths required 8 and 0",
                     pulse_cnt - p0, bad_w - b0);
        else n_pass++;
        for (int i = 0; i < 8; i++)
            if (r0 + i >= rise_q.size() || rise_q[r0+i] !== ((i < 4) ? 3'b001 : 3'b011)) seq_bad++;
        n_chk++;
        if (seq_bad != 0) $display("FAIL scan_ch_seq: %0d wrong {cal,ch_sel} at pulses required 0", seq_bad);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (gi >= got_q.size()) $display("FAIL scan_result: none, required ch %0d data %0d", e[11:10], e[9:0]);
            else begin
                if (got_q[gi] !== e)
                    $display("FAIL scan_result: ch %0d data %0d required ch %0d data %0d",
                             got_q[gi][11:10], got_q[gi][9:0], e[11:10], e[9:0]);
                else n_pass++;
                gi++;
            end
        end
    endtask

    task automatic test_backpressure();
        int p0 = pulse_cnt;
        int pv;
        int unstable = 0;
        bit ok;
        logic [9:0] d;
        logic [1:0] c;
        logic [11:0] e;
        adc_vals.push_back(10'd100); adc_vals.push_back(10'd101);
        adc_vals.push_back(10'd102); adc_vals.push_back(10'd104);
        repeat (4) adc_vals.push_back(10'd1023);
        exp_q.push_back({2'd1, 10'd101});
        exp_q.push_back({2'd3, 10'd1023});
        out_ready = 1'b0;
        pulse_start(4'b1010, 2'd2, 1'b0);
        for (int i = 0; i < 1000 && !out_valid; i++) tick();
        n_chk++;
        if (out_valid !== 1'b1) $display("FAIL bp_valid: out_valid %b required 1", out_valid);
        else n_pass++;
        d = out_data;
        c = out_ch;
        pv = pulse_cnt;
        repeat (10) begin
            tick();
            if (out_valid !== 1'b1 || out_data !== d || out_ch !== c || st_conv !== 1'b0) unstable++;
        end
        n_chk++;
        if (unstable != 0 || pulse_cnt != pv)
            $display("FAIL bp_hold: %0d unstable cycles %0d new pulses required 0 and 0", unstable, pulse_cnt - pv);
        else n_pass++;
        out_ready = 1'b1;
        wait_idle(1500, ok);
        n_chk++;
        if (!ok || pulse_cnt - p0 != 8)
            $display("FAIL bp_done: idle %0d pulses %0d required 1 and 8", ok, pulse_cnt - p0);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (gi >= got_q.size()) $display("FAIL bp_result: none, required ch %0d data %0d", e[11:10], e[9:0]);
            else begin
                if (got_q[gi] !== e)
                    $display("FAIL bp_result: ch %0d data %0d required ch %0d data %0d",
                             got_q[gi][11:10], got_q[gi][9:0], e[11:10], e[9:0]);
                else n_pass++;
                gi++;
            end
        end
    endtask

    task automatic test_simul_mask();
        int p0 = pulse_cnt;
        int r0 = rise_q.size();
        int busy_seen = 0;
        bit ok;
        logic [11:0] e;
        adc_vals.push_back(10'd0);
        adc_vals.push_back(10'd555);
        exp_q.push_back({2'd0, 10'd555});
        pulse_start(4'b0001, 2'd0, 1'b1);
        wait_idle(800, ok);
        n_chk++;
        if (!ok || pulse_cnt - p0 != 2)
            $display("FAIL simul_pulses: idle %0d pulses %0d required 1 and 2", ok, pulse_cnt - p0);
        else n_pass++;
        n_chk++;
        if (rise_q.size() != r0 + 2 || rise_q[r0] !== 3'b100 || rise_q[r0+1] !== 3'b000)
            $display("FAIL simul_order: %0d rises, last {cal,ch_sel}=%b required cal 100 then scan 000",
                     rise_q.size() - r0, rise_q[rise_q.size()-1]);
        else n_pass++;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (gi >= got_q.size()) $display("FAIL simul_result: none, required ch %0d data %0d", e[11:10], e[9:0]);
            else begin
                if (got_q[gi] !== e)
                    $display("FAIL simul_result: ch %0d data %0d required ch %0d data %0d",
                             got_q[gi][11:10], got_q[gi][9:0], e[11:10], e[9:0]);
                else n_pass++;
                gi++;
            end
        end
        p0 = pulse_cnt;
        pulse_start(4'b0000, 2'd1, 1'b0);
        repeat (8) begin
            if (busy !== 1'b0) busy_seen++;
            tick();
        end
        n_chk++;
        if (busy_seen != 0 || pulse_cnt != p0)
            $display("FAIL zero_mask: busy cycles %0d pulses %0d required 0 and 0", busy_seen, pulse_cnt - p0);
        else n_pass++;
    endtask

    task automatic test_timeout();
        int cnt = 0;
        bit ok;
        logic [11:0] e;
        adc_dead = 1'b1;
        pulse_start(4'b0001, 2'd0, 1'b0);
        for (int i = 0; i < 20 && !st_conv; i++) tick();
        for (int i = 0; i < 20 && st_conv; i++) tick();
        while (!timeout_err && cnt < 400) begin
            tick();
            cnt++;
        end
        n_chk++;
        if (cnt != TIMEOUT) $display("FAIL timeout_delay: %0d cycles after CONV entry required %0d", cnt, TIMEOUT);
        else n_pass++;
        n_chk++;
        if (timeout_err !== 1'b1 || st_conv !== 1'b0 || busy !== 1'b0)
            $display("FAIL timeout_state: err %b st_conv %b busy %b required 1 0 0", timeout_err, st_conv, busy);
        else n_pass++;
        tick(3);
        adc_dead = 1'b0;
        adc_vals.push_back(10'd7);
        exp_q.push_back({2'd0, 10'd7});
        pulse_start(4'b0001, 2'd0, 1'b0);
        n_chk++;
        if (timeout_err !== 1'b0) $display("FAIL timeout_clear: err %b required 0", timeout_err);
        else n_pass++;
        wait_idle(800, ok);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (gi >= got_q.size()) $display("FAIL timeout_result: none, required ch %0d data %0d", e[11:10], e[9:0]);
            else begin
                if (got_q[gi] !== e)
                    $display("FAIL timeout_result: ch %0d data %0d required ch %0d data %0d",
                             got_q[gi][11:10], got_q[gi][9:0], e[11:10], e[9:0]);
                else n_pass++;
                gi++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int p0;
        int busy_seen = 0;
        pulse_start(4'b1111, 2'd3, 1'b0);
        cal_req = 1'b1;
        tick();
        cal_req = 1'b0;
        tick();
        n_chk++;
        if (st_conv !== 1'b1) $display("FAIL rmid_sample: st_conv %b required 1", st_conv);
        else n_pass++;
        #2;
        rst = 1'b1;
        #1;
        n_chk++;
        if ({st_conv, cal, out_valid, busy, timeout_err, ch_sel, out_ch, out_data} !== '0)
            $display("FAIL rmid_async: got %b required 0",
                     {st_conv, cal, out_valid, busy, timeout_err, ch_sel, out_ch, out_data});
        else n_pass++;
        tick(2);
        rst = 1'b0;
        p0 = pulse_cnt;
        repeat (60) begin
            tick();
            if (busy !== 1'b0) busy_seen++;
        end
        n_chk++;
        if (busy_seen != 0 || pulse_cnt != p0)
            $display("FAIL rmid_no_resume: busy cycles %0d pulses %0d required 0 and 0", busy_seen, pulse_cnt - p0);
        else n_pass++;
    endtask

    initial begin
        tick(3);
        test_reset();
        test_cal();
        test_scan();
        test_backpressure();
        test_simul_mask();
        test_timeout();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d so far", n_pass, n_chk);
        $fatal(1);
    end

endmodule
